// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// select codes, stall vectors and the operand forwarding decision.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Stall bits are {wb,mem,ex,id,if,pc}.
  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_LOADUSE = 6'b000111;
  localparam logic [5:0] STALL_MC      = 6'b001111;

  // EX beats MEM; register 0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic       rd,
                                         input logic [4:0] addr,
                                         input logic       ex_wreg,
                                         input logic [4:0] ex_wd,
                                         input logic       mem_wreg,
                                         input logic [4:0] mem_wd);
    logic [1:0] sel;
    sel = FWD_RF;
    if (rd && (addr != 5'd0)) begin
      if (ex_wreg && (ex_wd == addr)) begin
        sel = FWD_EX;
      end else if (mem_wreg && (mem_wd == addr)) begin
        sel = FWD_MEM;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use interlock,
// multi-cycle EX op sequencing and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read,
  input  logic        id_reg2_read,
  input  logic [4:0]  id_reg1_addr,
  input  logic [4:0]  id_reg2_addr,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_wd,
  input  logic        ex_is_load,
  input  logic        mem_wreg,
  input  logic [4:0]  mem_wd,
  input  logic        ex_mc_start,
  input  logic [5:0]  ex_mc_cycles,
  input  logic        flush,
  output logic [5:0]  stall,
  output logic [1:0]  fwd1_sel,
  output logic [1:0]  fwd2_sel,
  output logic        mc_busy,
  output logic        mc_done,
  output logic [15:0] stall_cycles
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] stall_cycles_q;

  // Forwarding stays live through stalls and reset.
  assign fwd1_sel = fwd_sel(id_reg1_read, id_reg1_addr, ex_wreg, ex_wd, mem_wreg, mem_wd);
  assign fwd2_sel = fwd_sel(id_reg2_read, id_reg2_addr, ex_wreg, ex_wd, mem_wreg, mem_wd);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = STALL_NONE;
    mc_busy = 1'b0;
    mc_done = 1'b0;
    if (flush) begin
      state_d = StIdle;
      cnt_d   = 6'd0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          mc_done = (state_q == StDone);
          state_d = StIdle;
          if (ex_mc_start) begin
            stall   = STALL_MC;
            // Start cycle is itself the first stalled cycle.
            cnt_d   = (ex_mc_cycles == 6'd0) ? 6'd0 : ex_mc_cycles - 6'd1;
            state_d = (cnt_d != 6'd0) ? StBusy : StDone;
          end else if ((state_q == StIdle) && ex_is_load &&
                       ((fwd1_sel == FWD_EX) || (fwd2_sel == FWD_EX))) begin
            stall = STALL_LOADUSE;
          end
        end
        StBusy: begin
          stall   = STALL_MC;
          mc_busy = 1'b1;
          if (cnt_q == 6'd1) begin
            cnt_d   = 6'd0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 6'd0;
        end
      endcase
    end
    if (rst) begin
      stall   = STALL_NONE;
      mc_busy = 1'b0;
      mc_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= 6'd0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall[0] && (stall_cycles_q != 16'hFFFF)) begin
        stall_cycles_q <= stall_cycles_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_reg1_read, id_reg2_read;
  logic [4:0]  id_reg1_addr, id_reg2_addr;
  logic        ex_wreg, ex_is_load, mem_wreg;
  logic [4:0]  ex_wd, mem_wd;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        flush;
  logic [5:0]  stall;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic        mc_busy, mc_done;
  logic [15:0] stall_cycles;

  hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_reg1_read (id_reg1_read),
    .id_reg2_read (id_reg2_read),
    .id_reg1_addr (id_reg1_addr),
    .id_reg2_addr (id_reg2_addr),
    .ex_wreg      (ex_wreg),
    .ex_wd        (ex_wd),
    .ex_is_load   (ex_is_load),
    .mem_wreg     (mem_wreg),
    .mem_wd       (mem_wd),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .flush        (flush),
    .stall        (stall),
    .fwd1_sel     (fwd1_sel),
    .fwd2_sel     (fwd2_sel),
    .mc_busy      (mc_busy),
    .mc_done      (mc_done),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mask bits: [0] stall, [1] forwarding, [2] busy/done, [3] stall_cycles
  typedef struct packed {
    logic [3:0]  mask;
    logic [5:0]  stall;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic        busy;
    logic        done;
    logic [15:0] sc;
  } exp_t;

  localparam logic [3:0] M_ALL   = 4'hF;
  localparam logic [3:0] M_NOCNT = 4'h7;
  localparam logic [3:0] M_NONE  = 4'h0;

  exp_t        exp_q[$];
  string       name_q[$];
  int          passed = 0;
  int          total  = 0;
  logic [15:0] exp_sc = 16'd0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      logic  ok;
      e  = exp_q.pop_front();
      n  = name_q.pop_front();
      ok = 1'b1;
      if (e.mask[0] && (stall !== e.stall)) ok = 1'b0;
      if (e.mask[1] && ((fwd1_sel !== e.f1) || (fwd2_sel !== e.f2))) ok = 1'b0;
      if (e.mask[2] && ((mc_busy !== e.busy) || (mc_done !== e.done))) ok = 1'b0;
      if (e.mask[3] && (stall_cycles !== e.sc)) ok = 1'b0;
      if (e.mask != 4'h0) begin
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got stall=%b f1=%b f2=%b busy=%b done=%b sc=%h, want stall=%b f1=%b f2=%b busy=%b done=%b sc=%h (mask %b)",
                      n, stall, fwd1_sel, fwd2_sel, mc_busy, mc_done, stall_cycles,
                      e.stall, e.f1, e.f2, e.busy, e.done, e.sc, e.mask);
      end
    end
  end

  // Expired-wait watchdog.
  initial begin
    #20000000;
    total++;
    $display("FAIL timeout: bench did not finish in time");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  task automatic check_now(input string n, input logic cond);
    total++;
    if (cond) passed++;
    else $display("FAIL %s: stall=%b busy=%b done=%b sc=%h state=%0d",
                  n, stall, mc_busy, mc_done, stall_cycles, dut.state_q);
  endtask

  // Push this cycle's expectation, update the stall-count model, advance a cycle.
  task automatic step(input string n, input logic [3:0] m, input logic [5:0] st,
                      input logic [1:0] f1, input logic [1:0] f2,
                      input logic bz, input logic dn);
    exp_t e;
    e.mask = m; e.stall = st; e.f1 = f1; e.f2 = f2; e.busy = bz; e.done = dn; e.sc = exp_sc;
    exp_q.push_back(e);
    name_q.push_back(n);
    if (rst) exp_sc = 16'd0;
    else if (st[0] && (exp_sc != 16'hFFFF)) exp_sc = exp_sc + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_reg1_read = 0; id_reg2_read = 0; id_reg1_addr = 0; id_reg2_addr = 0;
    ex_wreg = 0; ex_wd = 0; ex_is_load = 0; mem_wreg = 0; mem_wd = 0;
    ex_mc_start = 0; ex_mc_cycles = 0; flush = 0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    step("reset0", M_NOCNT, STALL_NONE, FWD_RF, FWD_RF, 0, 0);
    step("reset1", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 0);
    check_now("reset_state", (stall === STALL_NONE) && (mc_busy === 1'b0) &&
              (mc_done === 1'b0) && (stall_cycles === 16'd0) && (dut.state_q == StIdle));
    rst = 1'b0;

    // ori $1 in EX, ID reads $1
    ex_wreg = 1; ex_wd = 1; id_reg1_read = 1; id_reg1_addr = 1;
    step("fwd_ex", M_ALL, STALL_NONE, FWD_EX, FWD_RF, 0, 0);
    // one unrelated instruction between
    ex_wd = 5; mem_wreg = 1; mem_wd = 1;
    step("fwd_mem", M_ALL, STALL_NONE, FWD_MEM, FWD_RF, 0, 0);
    ex_wd = 3; mem_wd = 3; id_reg1_addr = 3;
    step("ex_over_mem", M_ALL, STALL_NONE, FWD_EX, FWD_RF, 0, 0);
    ex_wd = 0; mem_wd = 0; id_reg1_addr = 0;
    step("no_fwd_r0", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 0);

    // lw $4 in EX, ID reads $4 on operand 2
    clr();
    ex_wreg = 1; ex_wd = 4; ex_is_load = 1; id_reg2_read = 1; id_reg2_addr = 4;
    step("loaduse", M_ALL, STALL_LOADUSE, FWD_RF, FWD_EX, 0, 0);
    ex_wreg = 0; ex_is_load = 0; mem_wreg = 1; mem_wd = 4;
    step("loaduse_after", M_ALL, STALL_NONE, FWD_RF, FWD_MEM, 0, 0);
    ex_wreg = 1; ex_wd = 7; ex_is_load = 1;
    step("load_nomatch", M_ALL, STALL_NONE, FWD_RF, FWD_MEM, 0, 0);
    ex_wd = 0; mem_wreg = 0; id_reg2_addr = 0;
    step("load_r0", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 0);

    // multi-cycle N=5
    clr();
    ex_mc_start = 1; ex_mc_cycles = 6'd5;
    step("mc5_start", M_ALL, STALL_MC, FWD_RF, FWD_RF, 0, 0);
    ex_mc_start = 0;
    step("mc5_busy1", M_ALL, STALL_MC, FWD_RF, FWD_RF, 1, 0);
    ex_mc_start = 1; ex_wreg = 1; ex_wd = 2; id_reg1_read = 1; id_reg1_addr = 2;
    step("mc5_busy2_fwd", M_ALL, STALL_MC, FWD_EX, FWD_RF, 1, 0);
    clr();
    step("mc5_busy3", M_ALL, STALL_MC, FWD_RF, FWD_RF, 1, 0);
    step("mc5_busy4", M_ALL, STALL_MC, FWD_RF, FWD_RF, 1, 0);
    step("mc5_done", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 1);
    step("mc5_idle", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 0);

    for (int n = 0; n < 2; n++) begin
      ex_mc_start = 1; ex_mc_cycles = 6'(n);
      step("mcN_start", M_ALL, STALL_MC, FWD_RF, FWD_RF, 0, 0);
      clr();
      step("mcN_done", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 1);
      step("mcN_idle", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 0);
    end

    // flush on third BUSY cycle
    ex_mc_start = 1; ex_mc_cycles = 6'd6;
    step("fl_start", M_ALL, STALL_MC, FWD_RF, FWD_RF, 0, 0);
    ex_mc_start = 0;
    step("fl_busy1", M_ALL, STALL_MC, FWD_RF, FWD_RF, 1, 0);
    step("fl_busy2", M_ALL, STALL_MC, FWD_RF, FWD_RF, 1, 0);
    flush = 1;
    step("fl_busy3", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 0);
    flush = 0;
    step("fl_idle", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 0);

    // priorities
    flush = 1; ex_mc_start = 1; ex_mc_cycles = 6'd4;
    step("prio_flush", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 0);
    clr();
    step("prio_flush_idle", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 0);
    ex_mc_start = 1; ex_mc_cycles = 6'd1;
    ex_wreg = 1; ex_wd = 9; ex_is_load = 1; id_reg1_read = 1; id_reg1_addr = 9;
    step("prio_mc_over_lu", M_ALL, STALL_MC, FWD_EX, FWD_RF, 0, 0);
    clr();
    step("prio_done", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 1);

    // reset during BUSY
    ex_mc_start = 1; ex_mc_cycles = 6'd10;
    step("rst_start", M_ALL, STALL_MC, FWD_RF, FWD_RF, 0, 0);
    ex_mc_start = 0;
    step("rst_busy1", M_ALL, STALL_MC, FWD_RF, FWD_RF, 1, 0);
    rst = 1; ex_wreg = 1; ex_wd = 1; id_reg1_read = 1; id_reg1_addr = 1;
    step("rst_in_busy", M_ALL, STALL_NONE, FWD_EX, FWD_RF, 0, 0);
    rst = 0;
    clr();
    step("rst_after", M_ALL, STALL_NONE, FWD_RF, FWD_RF, 0, 0);

    // saturation: start held high keeps every cycle stalled
    ex_mc_start = 1; ex_mc_cycles = 6'd63;
    for (int i = 0; i < 70000; i++) begin
      step("bulk", M_NONE, STALL_MC, FWD_RF, FWD_RF, 0, 0);
    end
    check_now("saturated_count", stall_cycles === 16'hFFFF);
    flush = 1;
    step("saturate", 4'b1001, STALL_NONE, FWD_RF, FWD_RF, 0, 0);
    clr();
    check_now("saturated_hold", stall_cycles === 16'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-003 SHALL have ports id_reg1_read and id_reg2_read, input, 1 each, ID stage reads operand 1 / operand 2.
REQ-004 SHALL have ports id_reg1_addr and id_reg2_addr, input, 5 each, ID operand register numbers.
REQ-005 SHALL have ports ex_wreg (input, 1), ex_wd (input, 5) and ex_is_load (input, 1), describing the EX-stage destination write and whether the EX instruction is a load.
REQ-006 SHALL have ports mem_wreg (input, 1) and mem_wd (input, 5), the MEM-stage destination write.
REQ-007 SHALL have ports ex_mc_start (input, 1) and ex_mc_cycles (input, 6), a multi-cycle EX op issue pulse and its length N.
REQ-008 SHALL have port flush, input, 1, pipeline flush (exception or redirect).
REQ-009 SHALL have port stall, output, 6, hold bits {wb,mem,ex,id,if,pc} (bit 0 = pc).
REQ-010 SHALL have ports fwd1_sel and fwd2_sel, output, 2 each: 00 regfile, 01 EX result, 10 MEM result; 11 is never driven.
REQ-011 SHALL have ports mc_busy and mc_done, output, 1 each, reporting the multi-cycle op state.
REQ-012 SHALL have port stall_cycles, output, 16, a saturating count of cycles with stall[0]=1.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 SHALL compute forwarding combinationally: an operand with read=1, addr!=0, ex_wreg=1 and ex_wd=addr selects 01; otherwise with mem_wreg=1 and mem_wd=addr it selects 10; otherwise 00.
REQ-015 SHALL give EX priority over MEM when both match, and SHALL never forward register 0.
REQ-016 SHALL raise a load-use stall in IDLE, without ex_mc_start or flush, when ex_is_load=1 and EX forwarding would be selected for either operand: stall=6'b000111 in that cycle only.
REQ-017 SHALL, in IDLE with ex_mc_start=1 and flush=0, drive stall=6'b001111 in that cycle, load the counter with max(N,1)-1, and go to BUSY if the counter is nonzero, else to DONE.
REQ-018 SHALL, in BUSY, drive stall=6'b001111 and mc_busy=1, decrement the counter each cycle, and go to DONE on the cycle the counter is 1.
REQ-019 SHALL give exactly max(N,1) stalled cycles in total, counting the start cycle.
REQ-020 SHALL, in DONE, hold for one cycle with mc_done=1 and stall=0, then return to IDLE; ex_mc_start seen in DONE is handled as in IDLE.
REQ-021 SHALL ignore ex_mc_start in BUSY.
REQ-022 SHALL apply priority flush > multi-cycle > load-use.
REQ-023 SHALL, when flush=1, drive stall=0 and mc_busy=0, clear the counter and go to IDLE next cycle from any state.
REQ-024 SHALL keep forwarding outputs valid even while stalled.
REQ-025 SHALL increment stall_cycles in each cycle with stall[0]=1 and saturate it at 16'hFFFF.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set state to IDLE and set the counter and stall_cycles to 0.
REQ-027 SHALL, while rst=1, drive stall=0, mc_busy=0 and mc_done=0, including reset asserted mid-BUSY.
REQ-028 SHALL NOT change forwarding select behaviour during reset; it stays combinational on its inputs.

Structure
REQ-029 SHALL place the FSM state encoding, the forwarding select codes (FWD_RF, FWD_EX, FWD_MEM) and the stall vector constants (STALL_NONE, STALL_LOADUSE, STALL_MC) in the shared defines/package.
REQ-030 SHALL be one module with no sub-module; it is instantiated in openmips next to the ctrl/ID stage.

Verification
REQ-031 SHALL cover: ori $1 then ori $2,$1 -> fwd1_sel=01, stall=0; the same with one unrelated instruction between them -> fwd1_sel=10.
REQ-032 SHALL cover: EX ex_wd=3 with ex_wreg=1 and MEM mem_wd=3 with mem_wreg=1, ID reading $3 -> fwd1_sel=01; ID reading $0 with ex_wd=0 -> fwd1_sel=00.
REQ-033 SHALL cover: lw $4 in EX with ID reading $4 via operand 2 -> stall=000111 for exactly 1 cycle, then fwd2_sel=10.
REQ-034 SHALL cover: ex_mc_start with N=5 -> stall=001111 for 5 cycles, then mc_done=1 for 1 cycle and stall=0; stall_cycles rises by 5.
REQ-035 SHALL cover: N=0 and N=1 -> 1 stalled cycle each; flush on the 3rd BUSY cycle -> stall=0 and state IDLE next cycle.
REQ-036 SHALL cover: rst asserted during BUSY -> all outputs 0 next cycle; 70000 forced stall cycles -> stall_cycles=16'hFFFF.
